// File: rtl/adc_cap_pkg.sv
// Shared types for the DDR ADC capture block: FSM state encoding and trigger-mode codes.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_EXTERNAL  = 2'd1;
  localparam logic [1:0] TRIG_THRESH    = 2'd2;
  localparam logic [1:0] TRIG_RESERVED  = 2'd3;

endpackage

// File: rtl/adc_cap_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags and a synchronous flush.
// A push while full is accepted when a pop happens in the same cycle.
module adc_cap_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/adc_ddr_capture.sv
// DDR ADC sample capture: lane assembly, triggering, decimation and a buffered output stream.
// Optional ramp test pattern (test_mode port) is built only when ADC_CAP_TEST_PATTERN_EN is defined.
module adc_ddr_capture
  import adc_cap_pkg::*;
#(
  parameter int LANES  = 8,
  parameter int DATA_W = 14,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  adc_rise,
  input  logic [LANES-1:0]  adc_fall,
  input  logic [1:0]        cfg_trig_mode,
  input  logic [15:0]       cfg_len,
  input  logic [3:0]        cfg_decim,
  input  logic              cfg_twos,
  input  logic [DATA_W-1:0] cfg_thresh,
  input  logic              start,
  input  logic              stop,
  input  logic              trig_in,
`ifdef ADC_CAP_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output cap_state_e        dbg_state
);

  localparam int RAW_W = 2 * LANES;
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  cap_state_e        state_q, state_d;
  logic [RAW_W-1:0]  raw_in, raw_d, raw_q;
  logic [DATA_W-1:0] sample, prev_q;
  logic              trig_q, trig_hit;
  logic [15:0]       cnt_q, cnt_d, cnt_inc;
  logic [3:0]        dcnt_q, dcnt_d;
  logic              done_q, done_d, ovf_q, ovf_d;
  logic [1:0]        mode_q;
  logic [15:0]       len_q;
  logic [3:0]        decim_q;
  logic              twos_q;
  logic [DATA_W-1:0] thresh_q;
  logic              want_push, flush, pop_fire, push_ok;
  logic              fifo_full, fifo_empty;

  always_comb begin
    raw_in = '0;
    for (int l = 0; l < LANES; l++) begin
      raw_in[2*l+1] = adc_rise[l];
      raw_in[2*l]   = adc_fall[l];
    end
  end

`ifdef ADC_CAP_TEST_PATTERN_EN
  logic [RAW_W-1:0] ramp_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ramp_q <= '0;
    else     ramp_q <= ramp_q + {{(RAW_W-1){1'b0}}, 1'b1};
  end
  assign raw_d = test_mode ? ramp_q : raw_in;
`else
  assign raw_d = raw_in;
`endif

  if (DATA_W < RAW_W) begin : g_unused
    logic unused_raw_bits;
    assign unused_raw_bits = ^raw_q[RAW_W-1:DATA_W];
  end

  assign sample   = raw_q[DATA_W-1:0] ^ (twos_q ? MSB_MASK : '0);
  assign pop_fire = m_valid && m_ready;
  assign push_ok  = !fifo_full || pop_fire;
  assign cnt_inc  = cnt_q + 16'd1;

  always_comb begin
    case (mode_q)
      TRIG_EXTERNAL: trig_hit = trig_in && !trig_q;
      TRIG_THRESH:   trig_hit = (prev_q < thresh_q) && (sample >= thresh_q);
      default:       trig_hit = 1'b1;
    endcase
  end

  // start has priority everywhere: it re-arms and, outside IDLE, flushes the buffer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    want_push = 1'b0;
    flush     = 1'b0;
    if (start) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
      dcnt_d  = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      flush   = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (trig_hit) begin
            want_push = 1'b1;
            dcnt_d    = (decim_q == 4'd0) ? 4'd0 : 4'd1;
            state_d   = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else begin
            want_push = (dcnt_q == 4'd0);
            dcnt_d    = (dcnt_q == decim_q) ? 4'd0 : dcnt_q + 4'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
      // Dropped samples raise ovf but never advance the length count.
      if (want_push) begin
        if (push_ok) begin
          cnt_d = cnt_inc;
          if (len_q != 16'd0 && cnt_inc == len_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      raw_q    <= '0;
      prev_q   <= '0;
      trig_q   <= 1'b0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      mode_q   <= TRIG_IMMEDIATE;
      len_q    <= '0;
      decim_q  <= '0;
      twos_q   <= 1'b0;
      thresh_q <= '0;
    end else begin
      state_q <= state_d;
      raw_q   <= raw_d;
      prev_q  <= sample;
      trig_q  <= trig_in;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      if (start) begin
        mode_q   <= cfg_trig_mode;
        len_q    <= cfg_len;
        decim_q  <= cfg_decim;
        twos_q   <= cfg_twos;
        thresh_q <= cfg_thresh;
      end
    end
  end

  adc_cap_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (want_push && push_ok),
    .wdata_i (sample),
    .pop_i   (pop_fire),
    .rdata_o (m_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign m_valid   = !fifo_empty;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_ddr_capture.sv
// Self-checking bench for adc_ddr_capture (LANES=8, DATA_W=14, DEPTH=4).
module tb_adc_ddr_capture;
  import adc_cap_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  adc_rise, adc_fall;
  logic [1:0]  cfg_trig_mode;
  logic [15:0] cfg_len;
  logic [3:0]  cfg_decim;
  logic        cfg_twos;
  logic [13:0] cfg_thresh;
  logic        start, stop, trig_in;
  logic [13:0] m_data;
  logic        m_valid, m_ready, busy, done, ovf;
  cap_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  logic [13:0] mon_exp;

  typedef struct {
    logic [7:0]  rise;
    logic [7:0]  fall;
    logic        twos;
    logic [15:0] len;
    logic [13:0] exp;
  } vec_t;
  vec_t vecs[9];

  adc_ddr_capture #(.LANES(8), .DATA_W(14), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .adc_rise(adc_rise), .adc_fall(adc_fall),
    .cfg_trig_mode(cfg_trig_mode), .cfg_len(cfg_len), .cfg_decim(cfg_decim),
    .cfg_twos(cfg_twos), .cfg_thresh(cfg_thresh), .start(start), .stop(stop),
    .trig_in(trig_in), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .ovf(ovf), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] fmt_model(input logic [7:0] r, input logic [7:0] f, input logic t);
    logic [15:0] raw;
    for (int l = 0; l < 8; l++) begin
      raw[2*l+1] = r[l];
      raw[2*l]   = f[l];
    end
    fmt_model = raw[13:0];
    if (t) fmt_model[13] = ~fmt_model[13];
  endfunction

  // driver tasks
  task automatic set_raw(input logic [15:0] v);
    for (int l = 0; l < 8; l++) begin
      adc_rise[l] = v[2*l+1];
      adc_fall[l] = v[2*l];
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name);
    repeat (2) @(negedge clk);
    check({name, "_busy"}, busy, 0);
    check({name, "_valid"}, m_valid, 0);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    adc_rise = v.rise; adc_fall = v.fall;
    cfg_trig_mode = 2'd0; cfg_len = v.len; cfg_decim = 4'd0; cfg_twos = v.twos;
    start = 1'b1;
    for (int i = 0; i < int'(v.len); i++) exp_q.push_back(v.exp);
    @(posedge clk); #1;
    start = 1'b0;
    // configuration changes after start must not take effect
    cfg_twos = ~v.twos; cfg_len = 16'd9; cfg_decim = 4'd2;
    wait_done("vec_done");
    wait_drain("vec_drain");
    wait_idle("vec_idle");
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("m_data", m_data, mon_exp);
      end
    end
  end

  initial begin
    rst = 1'b1; adc_rise = '0; adc_fall = '0; cfg_trig_mode = '0; cfg_len = '0;
    cfg_decim = '0; cfg_twos = 1'b0; cfg_thresh = '0; start = 1'b0; stop = 1'b0;
    trig_in = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // immediate-trigger vectors with constant lane data
    vecs[0] = '{8'h55, 8'h10, 1'b0, 16'd3, 14'h2322};
    vecs[1] = '{8'h55, 8'h10, 1'b1, 16'd3, 14'h0322};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 16'd2, 14'h2AAA};
    vecs[3] = '{8'h00, 8'hFF, 1'b1, 16'd1, 14'h3555};
    vecs[4] = '{8'h0F, 8'hF0, 1'b0, 16'd4, 14'h15AA};
    for (int i = 5; i < 9; i++) begin
      vecs[i].rise = 8'($urandom_range(0, 255));
      vecs[i].fall = 8'($urandom_range(0, 255));
      vecs[i].twos = 1'($urandom_range(0, 1));
      vecs[i].len  = 16'($urandom_range(1, 4));
      vecs[i].exp  = fmt_model(vecs[i].rise, vecs[i].fall, vecs[i].twos);
    end
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // threshold trigger on a rising ramp 0x2000..0x3F80
    @(posedge clk); #1;
    cfg_trig_mode = 2'd2; cfg_thresh = 14'h3000; cfg_len = 16'd2; cfg_twos = 1'b0;
    cfg_decim = 4'd0; set_raw(16'h2000); start = 1'b1;
    exp_q.push_back(14'h3000);
    exp_q.push_back(14'h3080);
    for (int i = 1; i < 64; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      set_raw(16'h2000 + 16'(i) * 16'h0080);
    end
    wait_done("thr_done");
    wait_drain("thr_drain");
    wait_idle("thr_idle");

    // decimation keeps every 4th sample of an input ramp
    @(posedge clk); #1;
    cfg_trig_mode = 2'd0; cfg_len = 16'd4; cfg_decim = 4'd3; cfg_twos = 1'b0;
    set_raw(16'd0); start = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(14'(4 * k));
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      set_raw(16'(i));
    end
    wait_done("dec_done");
    wait_drain("dec_drain");
    wait_idle("dec_idle");

    // overflow with the consumer stalled, then stop and drain
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        cfg_trig_mode = 2'd0; cfg_len = 16'd0; cfg_decim = 4'd0; cfg_twos = 1'b0;
      end
      start = (i == 0);
      set_raw(16'(i));
      @(negedge clk);
      if (i == 5) begin
        check("ovf_before_full", ovf, 0);
        check("valid_when_full", m_valid, 1);
      end
      if (i == 6) check("ovf_on_fifth", ovf, 1);
    end
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    @(negedge clk);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(14'(k));
    @(posedge clk); #1; m_ready = 1'b1;
    wait_drain("ovf_drain");
    wait_idle("ovf_idle");
    check("ovf_sticky", ovf, 1);

    // restart while capturing flushes and re-arms on an external trigger
    @(posedge clk); #1;
    m_ready = 1'b0; cfg_trig_mode = 2'd0; cfg_len = 16'd0; set_raw(16'h1234); start = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(negedge clk);
    check("pre_flush_ovf", ovf, 1);
    @(posedge clk); #1;
    cfg_trig_mode = 2'd1; cfg_len = 16'd2; cfg_twos = 1'b1;
    adc_rise = 8'h55; adc_fall = 8'h10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("flush_valid", m_valid, 0);
    check("flush_ovf", ovf, 0);
    check("flush_busy", busy, 1);
    repeat (4) @(negedge clk);
    check("ext_wait_valid", m_valid, 0);
    check("ext_wait_state", dbg_state, ST_ARMED);
    exp_q.push_back(14'h0322);
    exp_q.push_back(14'h0322);
    @(posedge clk); #1; m_ready = 1'b1; trig_in = 1'b1;
    wait_done("ext_done");
    wait_drain("ext_drain");
    wait_idle("ext_idle");
    trig_in = 1'b0;

    // asynchronous reset in the middle of a capture
    @(posedge clk); #1;
    m_ready = 1'b0; cfg_trig_mode = 2'd0; cfg_len = 16'd0; cfg_twos = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cap_valid", m_valid, 1);
    check("cap_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_valid", m_valid, 0);
    check("async_busy", busy, 0);
    check("async_data", m_data, 0);
    check("async_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", m_valid, 0);
    check("post_rst_ovf", ovf, 0);
    check("post_rst_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
